// File: rtl/tmr_error_pkg.sv
// tmr_error_pkg: shared FSM state type and index-width helper for the TMR error collector
package tmr_error_pkg;
    typedef enum logic {SCAN, PRESENT} state_t;
    function automatic int clog2_min1(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/tmr_error_counter.sv
// tmr_error_counter: per-source rising-edge event counter with saturation and zero-on-read
module tmr_error_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_err,
    input  logic             i_zero,
    output logic [CNT_W-1:0] o_count,
    output logic             o_nz,
    output logic             o_sat
);
    logic             r_err_q;
    logic [CNT_W-1:0] r_cnt;
    logic             w_rise;
    logic             w_max;
    assign w_rise  = i_err & ~r_err_q;
    assign w_max   = &r_cnt;
    assign o_sat   = w_rise & w_max & ~i_zero & ~i_clear;
    assign o_count = r_cnt;
    assign o_nz    = |r_cnt;
    // a rise in the same cycle as the read survives as the first event of the next batch
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_q <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_err_q <= i_err;
            r_cnt   <= i_clear ? '0 :
                       i_zero ? CNT_W'(w_rise) :
                       (w_rise && !w_max) ? r_cnt + CNT_W'(1) : r_cnt;
        end
    end
endmodule

// File: rtl/tmr_error_collector.sv
// tmr_error_collector: counts per-source TMR error events and drains them round-robin over valid/ready
module tmr_error_collector
    import tmr_error_pkg::*;
#(
    parameter int N     = 10,
    parameter int CNT_W = 8,
    parameter int IDX_W = clog2_min1(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     err_i,
    input  logic             clear_i,
    output logic             rd_valid_o,
    input  logic             rd_ready_i,
    output logic [IDX_W-1:0] rd_index_o,
    output logic [CNT_W-1:0] rd_count_o,
    output logic             any_err_o,
    output logic             overflow_o
);
    logic [CNT_W-1:0] w_cnt [N];
    logic [N-1:0]     w_nz;
    logic [N-1:0]     w_sat;
    logic [N-1:0]     w_zero;
    logic             w_take;
    state_t           r_state;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] r_index;
    logic [CNT_W-1:0] r_count;
    logic             r_valid;
    logic             r_any;
    logic             r_overflow;
    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v);
        return (v == IDX_W'(N - 1)) ? '0 : v + IDX_W'(1);
    endfunction
    assign w_take = (r_state == SCAN) && w_nz[r_ptr] && !clear_i;
    for (genvar i = 0; i < N; i++) begin : g_cnt
        assign w_zero[i] = w_take && (r_ptr == IDX_W'(i));
        tmr_error_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk     (clk),
            .rst     (rst),
            .i_clear (clear_i),
            .i_err   (err_i[i]),
            .i_zero  (w_zero[i]),
            .o_count (w_cnt[i]),
            .o_nz    (w_nz[i]),
            .o_sat   (w_sat[i])
        );
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= SCAN;
            r_ptr      <= '0;
            r_index    <= '0;
            r_count    <= '0;
            r_valid    <= 1'b0;
            r_any      <= 1'b0;
            r_overflow <= 1'b0;
        end else if (clear_i) begin
            r_state    <= SCAN;
            r_ptr      <= '0;
            r_index    <= '0;
            r_count    <= '0;
            r_valid    <= 1'b0;
            r_any      <= |w_nz;
            r_overflow <= 1'b0;
        end else begin
            r_any      <= |w_nz;
            r_overflow <= r_overflow | (|w_sat);
            if (r_state == SCAN) begin
                if (w_take) begin
                    r_index <= r_ptr;
                    r_count <= w_cnt[r_ptr];
                    r_valid <= 1'b1;
                    r_state <= PRESENT;
                end else begin
                    r_ptr <= wrap_inc(r_ptr);
                end
            end else if (rd_ready_i) begin
                r_valid <= 1'b0;
                r_ptr   <= wrap_inc(r_index);
                r_state <= SCAN;
            end
        end
    end
    assign rd_valid_o = r_valid;
    assign rd_index_o = r_index;
    assign rd_count_o = r_count;
    assign any_err_o  = r_any;
    assign overflow_o = r_overflow;
endmodule

// File: tb/tb_tmr_error_collector.sv
// tb_tmr_error_collector: directed scenario bench for the TMR error collector
module tb_tmr_error_collector;
    localparam int N     = 10;
    localparam int CNT_W = 4;
    localparam int IDX_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     err_i = '0;
    logic             clear_i = 1'b0;
    logic             rd_ready_i = 1'b0;
    logic             rd_valid_o;
    logic [IDX_W-1:0] rd_index_o;
    logic [CNT_W-1:0] rd_count_o;
    logic             any_err_o;
    logic             overflow_o;
    int               tests = 0;
    int               fails = 0;

    tmr_error_collector #(.N(N), .CNT_W(CNT_W), .IDX_W(IDX_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .err_i      (err_i),
        .clear_i    (clear_i),
        .rd_valid_o (rd_valid_o),
        .rd_ready_i (rd_ready_i),
        .rd_index_o (rd_index_o),
        .rd_count_o (rd_count_o),
        .any_err_o  (any_err_o),
        .overflow_o (overflow_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int k);
        err_i[k] = 1'b1;
        tick();
        err_i[k] = 1'b0;
        tick();
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = rd_valid_o;
        for (int c = 0; c < budget && !ok; c++) begin
            tick();
            ok = rd_valid_o;
        end
    endtask

    task automatic handshake();
        rd_ready_i = 1'b1;
        tick();
        rd_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        tests++; if (rd_valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", rd_valid_o); end
        tests++; if (rd_index_o !== 4'd0) begin fails++; $display("FAIL reset_index got %0d want 0", rd_index_o); end
        tests++; if (rd_count_o !== 4'd0) begin fails++; $display("FAIL reset_count got %0d want 0", rd_count_o); end
        tests++; if (any_err_o !== 1'b0) begin fails++; $display("FAIL reset_any got %b want 0", any_err_o); end
        tests++; if (overflow_o !== 1'b0) begin fails++; $display("FAIL reset_overflow got %b want 0", overflow_o); end
        rst = 1'b0;
    endtask

    task automatic test_single_event();
        bit ok;
        pulse(3);
        tests++; if (any_err_o !== 1'b1) begin fails++; $display("FAIL single_any got %b want 1", any_err_o); end
        wait_valid(N, ok);
        tests++; if (!ok) begin fails++; $display("FAIL single_valid_timeout got 0 want 1"); end
        tests++; if (rd_index_o !== 4'd3) begin fails++; $display("FAIL single_index got %0d want 3", rd_index_o); end
        tests++; if (rd_count_o !== 4'd1) begin fails++; $display("FAIL single_count got %0d want 1", rd_count_o); end
        handshake();
        tests++; if (rd_valid_o !== 1'b0) begin fails++; $display("FAIL single_valid_drop got %b want 0", rd_valid_o); end
        tests++; if (any_err_o !== 1'b0) begin fails++; $display("FAIL single_any_clear got %b want 0", any_err_o); end
    endtask

    task automatic test_level_and_accumulate();
        bit ok;
        err_i[0] = 1'b1;
        repeat (20) tick();
        err_i[0] = 1'b0;
        tick();
        repeat (5) pulse(0);
        tests++; if (rd_valid_o !== 1'b1) begin fails++; $display("FAIL level_valid got %b want 1", rd_valid_o); end
        tests++; if (rd_index_o !== 4'd0) begin fails++; $display("FAIL level_index got %0d want 0", rd_index_o); end
        tests++; if (rd_count_o !== 4'd1) begin fails++; $display("FAIL level_count got %0d want 1", rd_count_o); end
        handshake();
        wait_valid(N + 2, ok);
        tests++; if (!ok) begin fails++; $display("FAIL accum_valid_timeout got 0 want 1"); end
        tests++; if (rd_index_o !== 4'd0) begin fails++; $display("FAIL accum_index got %0d want 0", rd_index_o); end
        tests++; if (rd_count_o !== 4'd5) begin fails++; $display("FAIL accum_count got %0d want 5", rd_count_o); end
        handshake();
    endtask

    task automatic test_saturation_clear();
        bit ok;
        pulse(7);
        wait_valid(N + 2, ok);
        tests++; if (!ok || rd_index_o !== 4'd7 || rd_count_o !== 4'd1) begin fails++; $display("FAIL sat_first got valid=%b idx=%0d cnt=%0d want 1/7/1", ok, rd_index_o, rd_count_o); end
        repeat (15) pulse(7);
        tests++; if (overflow_o !== 1'b0) begin fails++; $display("FAIL sat_no_overflow_at_15 got %b want 0", overflow_o); end
        repeat (5) pulse(7);
        tests++; if (overflow_o !== 1'b1) begin fails++; $display("FAIL sat_overflow got %b want 1", overflow_o); end
        tests++; if (rd_count_o !== 4'd1) begin fails++; $display("FAIL sat_hold_count got %0d want 1", rd_count_o); end
        handshake();
        wait_valid(N + 2, ok);
        tests++; if (!ok || rd_index_o !== 4'd7 || rd_count_o !== 4'd15) begin fails++; $display("FAIL sat_entry got valid=%b idx=%0d cnt=%0d want 1/7/15", ok, rd_index_o, rd_count_o); end
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        tests++; if (rd_valid_o !== 1'b0) begin fails++; $display("FAIL clear_valid got %b want 0", rd_valid_o); end
        tests++; if (overflow_o !== 1'b0) begin fails++; $display("FAIL clear_overflow got %b want 0", overflow_o); end
        tick();
        tests++; if (any_err_o !== 1'b0) begin fails++; $display("FAIL clear_any got %b want 0", any_err_o); end
    endtask

    task automatic test_round_robin();
        int got = 0;
        logic [IDX_W-1:0] idx [3];
        logic [CNT_W-1:0] cnt [3];
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        rd_ready_i = 1'b1;
        err_i = 10'b10_0010_0100;
        tick();
        err_i = '0;
        for (int c = 0; c < 40; c++) begin
            if (rd_valid_o && got < 3) begin
                idx[got] = rd_index_o;
                cnt[got] = rd_count_o;
                got++;
            end
            tick();
        end
        rd_ready_i = 1'b0;
        tests++; if (got != 3) begin fails++; $display("FAIL rr_entries got %0d want 3", got); end
        else begin
            tests++; if (idx[0] !== 4'd2 || idx[1] !== 4'd5 || idx[2] !== 4'd9) begin fails++; $display("FAIL rr_order got %0d,%0d,%0d want 2,5,9", idx[0], idx[1], idx[2]); end
            tests++; if (cnt[0] !== 4'd1 || cnt[1] !== 4'd1 || cnt[2] !== 4'd1) begin fails++; $display("FAIL rr_counts got %0d,%0d,%0d want 1,1,1", cnt[0], cnt[1], cnt[2]); end
        end
    endtask

    task automatic test_latch_collision();
        bit ok;
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        err_i[4] = 1'b1;
        tick();
        err_i[4] = 1'b0;
        repeat (3) tick();
        err_i[4] = 1'b1;
        tick();
        err_i[4] = 1'b0;
        tests++; if (rd_valid_o !== 1'b1 || rd_index_o !== 4'd4 || rd_count_o !== 4'd1) begin fails++; $display("FAIL coll_latch got valid=%b idx=%0d cnt=%0d want 1/4/1", rd_valid_o, rd_index_o, rd_count_o); end
        handshake();
        wait_valid(N + 2, ok);
        tests++; if (!ok || rd_index_o !== 4'd4 || rd_count_o !== 4'd1) begin fails++; $display("FAIL coll_next got valid=%b idx=%0d cnt=%0d want 1/4/1", ok, rd_index_o, rd_count_o); end
        handshake();
    endtask

    task automatic test_reset_while_present();
        bit ok;
        pulse(6);
        wait_valid(N + 2, ok);
        tests++; if (!ok || rd_index_o !== 4'd6) begin fails++; $display("FAIL rstp_present got valid=%b idx=%0d want 1/6", ok, rd_index_o); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++; if ({rd_valid_o, rd_index_o, rd_count_o, any_err_o, overflow_o} !== 11'd0) begin fails++; $display("FAIL rstp_outputs got v=%b i=%0d c=%0d a=%b o=%b want all 0", rd_valid_o, rd_index_o, rd_count_o, any_err_o, overflow_o); end
        err_i[1] = 1'b1;
        tick();
        err_i[1] = 1'b0;
        tests++; if (rd_valid_o !== 1'b0) begin fails++; $display("FAIL rstp_early_valid got %b want 0", rd_valid_o); end
        tick();
        tests++; if (rd_valid_o !== 1'b1 || rd_index_o !== 4'd1 || rd_count_o !== 4'd1) begin fails++; $display("FAIL rstp_scan_from_0 got valid=%b idx=%0d cnt=%0d want 1/1/1", rd_valid_o, rd_index_o, rd_count_o); end
    endtask

    initial begin
        test_reset();
        test_single_event();
        test_level_and_accumulate();
        test_saturation_clear();
        test_round_robin();
        test_latch_collision();
        test_reset_while_present();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
